cvxif_issue_queue: RTL and testbench

Coprocessor-side front end of the CV-X-IF link. Sits directly downstream of the core's CV-X-IF request port. It decodes each offered instruction and answers accept or reject. Accepted instructions are buffered in order until the core commits or kills them. Committed entries are executed one at a time on a simple integer ALU, and their write-back results are returned to the core through a valid/ready result channel.

---
 rtl/cvxif_issue_queue.sv | 173 +++++++++++++++++
 tb/tb_cvxif_issue_queue.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_issue_queue.sv
// CV-X-IF coprocessor front end: decodes offered instructions and buffers the
// accepted ones in order. Committed entries run on a small ALU and return results.
module cvxif_issue_queue #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IdWidth = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] FULL = (PtrW+1)'(Depth);

  typedef enum logic [1:0] {
    ST_PENDING   = 2'd0,
    ST_COMMITTED = 2'd1,
    ST_KILLED    = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    ent_state_e         state;
  } entry_t;

  entry_t           ent_q [Depth];
  logic [Depth-1:0] vld_q;
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       f3_ok;
  logic       unused_instr;

  assign opcode       = issue_instr_i[6:0];
  assign funct3       = issue_instr_i[14:12];
  assign funct7       = issue_instr_i[31:25];
  assign unused_instr = ^issue_instr_i[24:15];

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110, 3'b111: f3_ok = 1'b1;
      default:                                f3_ok = 1'b0;
    endcase
  end

  assign issue_accept_o    = (opcode == 7'b1111011) && (funct7 == 7'd0) && f3_ok;
  assign issue_writeback_o = issue_accept_o;

  // Ready looks only at registered count, so a same-cycle pop never frees a full queue.
  assign issue_ready_o = rst_ni && (count != FULL) && (&issue_rs_valid_i);

  logic hs;
  logic push;
  assign hs   = issue_valid_i && issue_ready_o;
  assign push = hs && issue_accept_o;

  // A commit for the id being pushed this cycle lands directly in the new entry.
  entry_t new_ent;
  always_comb begin
    new_ent        = '0;
    new_ent.id     = issue_id_i;
    new_ent.funct3 = funct3;
    new_ent.rd     = issue_instr_i[11:7];
    new_ent.rs1    = issue_rs1_i;
    new_ent.rs2    = issue_rs2_i;
    new_ent.state  = ST_PENDING;
    if (commit_valid_i && (commit_id_i == issue_id_i))
      new_ent.state = commit_kill_i ? ST_KILLED : ST_COMMITTED;
  end

  function automatic logic [XLEN-1:0] alu(input logic [2:0] op,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    case (op)
      3'b001:  alu = a - b;
      3'b100:  alu = a ^ b;
      3'b110:  alu = a | b;
      3'b111:  alu = a & b;
      default: alu = a + b;
    endcase
  endfunction

  entry_t head;
  logic   head_vld;
  logic   res_free;
  logic   pop_kill;
  logic   pop_load;
  logic   pop;

  assign head     = ent_q[rd_ptr];
  assign head_vld = vld_q[rd_ptr];
  assign res_free = !result_valid_o || result_ready_i;
  assign pop_kill = head_vld && (head.state == ST_KILLED);
  assign pop_load = head_vld && (head.state == ST_COMMITTED) && res_free;
  assign pop      = pop_kill || pop_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) ent_q[i] <= '0;
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (commit_valid_i && vld_q[i] && (ent_q[i].state == ST_PENDING) &&
            (ent_q[i].id == commit_id_i))
          ent_q[i].state <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      // The push slot is never the head being popped: a push needs count<Depth,
      // and wr_ptr==rd_ptr below full means the queue is empty.
      if (push) begin
        ent_q[wr_ptr] <= new_ent;
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
    end else if (pop_load) begin
      result_valid_o <= 1'b1;
      result_id_o    <= head.id;
      result_data_o  <= alu(head.funct3, head.rs1, head.rs2);
      result_rd_o    <= head.rd;
    end else if (result_valid_o && result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end

  assign result_we_o = result_valid_o;

endmodule

// File: tb/tb_cvxif_issue_queue.sv
// Directed bench for cvxif_issue_queue: decode, ordering, kill, backpressure, reset.
module tb_cvxif_issue_queue;
  logic        clk_i;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i;
  logic [63:0] issue_rs1_i;
  logic [63:0] issue_rs2_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i;
  logic [2:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [2:0]  result_id_o;
  logic [63:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  int errors;
  int checks;

  localparam logic [2:0] F_ADD = 3'b000, F_SUB = 3'b001, F_XOR = 3'b100,
                         F_OR  = 3'b110, F_AND = 3'b111;

  cvxif_issue_queue #(.Depth(4), .XLEN(64), .IdWidth(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    mk = {7'b0, 10'b0, f3, rd, 7'b1111011};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs1_i      = '0;
    issue_rs2_i      = '0;
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
  endtask

  task automatic offer(input logic [2:0] f3, input logic [4:0] rd, input logic [2:0] id,
                       input logic [63:0] a, input logic [63:0] b);
    issue_valid_i = 1'b1;
    issue_instr_i = mk(f3, rd);
    issue_id_i    = id;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
  endtask

  task automatic commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    result_ready_i = 1'b1;
    idle();
    #12;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", issue_ready_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", result_valid_o); end
    checks++; if (result_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", result_we_o); end
    checks++; if ({result_id_o, result_rd_o, result_data_o} !== '0) begin
      errors++; $display("FAIL reset_fields: id=%0d rd=%0d data=%h exp 0", result_id_o, result_rd_o, result_data_o);
    end
    rst_ni = 1'b1;
    tick();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", issue_ready_o); end
  endtask

  task automatic test_add();
    offer(F_ADD, 5'd5, 3'd2, 64'd5, 64'd7);
    commit(3'd2, 1'b0);
    #1;
    checks++; if (issue_accept_o !== 1'b1) begin errors++; $display("FAIL add_accept: got %b exp 1", issue_accept_o); end
    checks++; if (issue_writeback_o !== 1'b1) begin errors++; $display("FAIL add_wb: got %b exp 1", issue_writeback_o); end
    tick();
    idle();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL add_n1_valid: got %b exp 0", result_valid_o); end
    tick();
    checks++; if (result_valid_o !== 1'b1 || result_we_o !== 1'b1) begin
      errors++; $display("FAIL add_n2_valid: valid=%b we=%b exp 1 1", result_valid_o, result_we_o);
    end
    checks++; if (result_id_o !== 3'd2 || result_data_o !== 64'd12 || result_rd_o !== 5'd5) begin
      errors++; $display("FAIL add_n2_fields: id=%0d data=%0d rd=%0d exp 2 12 5", result_id_o, result_data_o, result_rd_o);
    end
    tick();
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL add_drain: got %b exp 0", result_valid_o); end
  endtask

  task automatic test_reject();
    logic exp_acc;
    for (int f = 0; f < 8; f++) begin
      issue_instr_i = mk(3'(f), 5'd1);
      exp_acc = (f == 0 || f == 1 || f == 4 || f == 6 || f == 7);
      #1;
      checks++; if (issue_accept_o !== exp_acc || issue_writeback_o !== exp_acc) begin
        errors++; $display("FAIL decode_f3_%0d: acc=%b wb=%b exp %b", f, issue_accept_o, issue_writeback_o, exp_acc);
      end
    end
    issue_instr_i = mk(F_ADD, 5'd1) | 32'h0200_0000;
    #1;
    checks++; if (issue_accept_o !== 1'b0) begin errors++; $display("FAIL decode_funct7: got %b exp 0", issue_accept_o); end
    issue_rs_valid_i = 2'b01;
    #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL rs_valid_ready: got %b exp 0", issue_ready_o); end
    issue_rs_valid_i = 2'b11;
    issue_valid_i = 1'b1;
    issue_instr_i = {7'b0, 10'b0, 3'b000, 5'd3, 7'b0110011};
    issue_id_i    = 3'd4;
    commit(3'd4, 1'b0);
    #1;
    checks++; if (issue_accept_o !== 1'b0) begin errors++; $display("FAIL reject_accept: got %b exp 0", issue_accept_o); end
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reject_result_c%0d: got %b exp 0", c, result_valid_o); end
      tick();
    end
  endtask

  task automatic test_full();
    logic [63:0] ra  [4] = '{64'd0, 64'd50, 64'h8000_0000_0000_0000, 64'd7};
    logic [63:0] rb  [4] = '{64'd1, 64'd8, 64'd1, 64'd7};
    logic [63:0] exp [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0};
    logic [2:0]  eid;
    result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(F_SUB, 5'(i + 1), 3'(i), ra[i], rb[i]);
      #1;
      checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b exp 1", i, issue_ready_o); end
      tick();
    end
    offer(F_SUB, 5'd9, 3'd4, 64'd1, 64'd1);
    #1;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_5th_ready: got %b exp 0", issue_ready_o); end
    tick();
    idle();
    for (int t = 0; t < 7; t++) begin
      if (t < 4) commit(3'(t), 1'b0); else commit_valid_i = 1'b0;
      #1;
      if (t >= 2 && t < 6) begin
        eid = 3'(t - 2);
        checks++; if (result_valid_o !== 1'b1 || result_id_o !== eid || result_data_o !== exp[t-2] ||
                      result_rd_o !== 5'(t - 1)) begin
          errors++; $display("FAIL full_res_%0d: v=%b id=%0d data=%h rd=%0d exp 1 %0d %h %0d",
                             t - 2, result_valid_o, result_id_o, result_data_o, result_rd_o, eid, exp[t-2], t - 1);
        end
      end else if (t == 6) begin
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL full_tail: got %b exp 0", result_valid_o); end
      end
      tick();
    end
    idle();
    for (int t = 0; t < 7; t++) begin
      if (t < 4) begin
        offer(F_ADD, 5'(10 + t), 3'(4 + t), 64'(t), 64'hFFFF_FFFF_FFFF_FFFF);
        commit(3'(4 + t), 1'b0);
      end else idle();
      #1;
      if (t >= 2 && t < 6) begin
        eid = 3'(t + 2);
        checks++; if (result_valid_o !== 1'b1 || result_id_o !== eid ||
                      result_data_o !== 64'(t - 3) || result_rd_o !== 5'(t + 8)) begin
          errors++; $display("FAIL wrap_res_%0d: v=%b id=%0d data=%h rd=%0d exp 1 %0d %h %0d",
                             t - 2, result_valid_o, result_id_o, result_data_o, result_rd_o, eid, 64'(t - 3), t + 8);
        end
      end else if (t == 6) begin
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_tail: got %b exp 0", result_valid_o); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_kill();
    logic [2:0]  got_id [4];
    logic [63:0] got_d  [4];
    int n;
    n = 0;
    result_ready_i = 1'b1;
    offer(F_XOR, 5'd1, 3'd1, 64'hF0F0, 64'hFF00); tick();
    offer(F_OR,  5'd2, 3'd2, 64'hF0F0, 64'hFF00); tick();
    offer(F_AND, 5'd3, 3'd3, 64'hF0F0, 64'hFF00); tick();
    idle();
    commit(3'd2, 1'b1); tick();
    commit(3'd1, 1'b0); tick();
    commit(3'd3, 1'b0); tick();
    idle();
    for (int c = 0; c < 10; c++) begin
      if (result_valid_o === 1'b1) begin
        if (n < 4) begin got_id[n] = result_id_o; got_d[n] = result_data_o; end
        n++;
      end
      tick();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL kill_count: got %0d exp 2", n); end
    if (n >= 2) begin
      checks++; if (got_id[0] !== 3'd1 || got_d[0] !== 64'h0FF0) begin
        errors++; $display("FAIL kill_first: id=%0d data=%h exp 1 0ff0", got_id[0], got_d[0]);
      end
      checks++; if (got_id[1] !== 3'd3 || got_d[1] !== 64'hF000) begin
        errors++; $display("FAIL kill_second: id=%0d data=%h exp 3 f000", got_id[1], got_d[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    result_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(F_ADD, 5'(20 + k), 3'(5 + k), 64'(k), 64'd100);
      commit(3'(5 + k), 1'b0);
      tick();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd5 || result_data_o !== 64'd100 ||
                    result_rd_o !== 5'd20) begin
        errors++; $display("FAIL hold_c%0d: v=%b id=%0d data=%0d rd=%0d exp 1 5 100 20",
                           c, result_valid_o, result_id_o, result_data_o, result_rd_o);
      end
      tick();
    end
    result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 3) begin
        checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'(5 + k) ||
                      result_data_o !== 64'(100 + k) || result_rd_o !== 5'(20 + k)) begin
          errors++; $display("FAIL b2b_%0d: v=%b id=%0d data=%0d rd=%0d exp 1 %0d %0d %0d",
                             k, result_valid_o, result_id_o, result_data_o, result_rd_o, 5 + k, 100 + k, 20 + k);
        end
      end else begin
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b exp 0", result_valid_o); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(F_ADD, 5'(k + 1), 3'(k), 64'(k), 64'd1);
      commit(3'(k), 1'b0);
      tick();
    end
    idle();
    tick();
    checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd0) begin
      errors++; $display("FAIL mid_pre: v=%b id=%0d exp 1 0", result_valid_o, result_id_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++; if (result_valid_o !== 1'b0 || result_data_o !== 64'd0 || issue_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset: v=%b data=%h ready=%b exp 0 0 0", result_valid_o, result_data_o, issue_ready_o);
    end
    #2;
    rst_ni = 1'b1;
    result_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mid_spurious_c%0d: got %b exp 0", c, result_valid_o); end
    end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b exp 1", issue_ready_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_reject();
    test_full();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
